bimodal_pht_ctrl: RTL and testbench

//  Sequences the 512x2-bit single-port bimodal pattern-history table (PHT) SRAM for the frontend predictor.

---
 rtl/pht_pkg.sv | 29 ++
 rtl/pht_upd_fifo.sv | 52 +++++
 rtl/bimodal_pht_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bimodal_pht_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pht_pkg.sv
// Shared types, sizes and the saturating-counter helper for the bimodal PHT controller.
package pht_pkg;

  localparam int IDX_W = 9;

  typedef logic [1:0] ctr_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_ent_t;

  typedef enum logic [1:0] {
    INIT   = 2'b00,
    RUN    = 2'b01,
    UPD_WR = 2'b10
  } state_e;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small FIFO of pending branch-resolution updates; head is visible combinationally.
module pht_upd_fifo
  import pht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  upd_ent_t din,
  output upd_ent_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  upd_ent_t         mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; a push and pop in the same cycle keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == (PW+1)'(DEPTH));
  assign empty = (count_r == {(PW+1){1'b0}});

endmodule

// File: rtl/bimodal_pht_ctrl.sv
// Single-port PHT SRAM sequencer: init sweep, predict lookups and queued counter RMW updates.
// Optional event counters are built when PHT_PERF_EN is defined.
module bimodal_pht_ctrl
  import pht_pkg::*;
#(
  parameter int   UPD_DEPTH  = 4,
  parameter int   STARVE_MAX = 8,
  parameter ctr_t INIT_CTR   = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_resp_valid,
  output logic [1:0]       pred_ctr,
  output logic             pred_taken,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             init_done,
  output logic             sram_csb,
  output logic             sram_web,
  output logic [IDX_W-1:0] sram_addr,
  output logic [1:0]       sram_din,
  input  logic [1:0]       sram_dout
`ifdef PHT_PERF_EN
  ,
  output logic [31:0]      perf_pred,
  output logic [31:0]      perf_upd,
  output logic [31:0]      perf_starve
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e           state_r, state_s;
  logic [IDX_W-1:0] ptr_r;
  logic [SW-1:0]    starve_cnt_r;
  logic             pred_resp_valid_r;
  logic             init_done_r;

  logic             csb_s, web_s, pred_ready_s, pop_s, push_s, upd_rd_s;
  logic [IDX_W-1:0] addr_s;
  ctr_t             din_s;
  upd_ent_t         upd_ent_s, head_s;
  logic             fifo_full_s, fifo_empty_s;

  assign upd_ent_s.idx   = upd_idx;
  assign upd_ent_s.taken = upd_taken;
  // The UPD_WR pop frees a slot in the same cycle, so a full queue can still accept.
  assign upd_ready = !fifo_full_s || pop_s;
  assign push_s    = upd_valid && upd_ready;

  pht_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (upd_ent_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Port arbitration and next-state selection.
  always_comb begin
    state_s      = state_r;
    csb_s        = 1'b1;
    web_s        = 1'b1;
    addr_s       = {IDX_W{1'b0}};
    din_s        = 2'b00;
    pred_ready_s = 1'b0;
    pop_s        = 1'b0;
    upd_rd_s     = 1'b0;
    case (state_r)
      INIT: begin
        csb_s  = 1'b0;
        web_s  = 1'b0;
        addr_s = ptr_r;
        din_s  = INIT_CTR;
        if (ptr_r == {IDX_W{1'b1}}) state_s = RUN;
        else                        state_s = INIT;
      end
      RUN: begin
        if (!fifo_empty_s && (fifo_full_s || (starve_cnt_r == SW'(STARVE_MAX)) || !pred_valid)) begin
          csb_s    = 1'b0;
          addr_s   = head_s.idx;
          upd_rd_s = 1'b1;
          state_s  = UPD_WR;
        end else if (pred_valid) begin
          csb_s        = 1'b0;
          addr_s       = pred_idx;
          pred_ready_s = 1'b1;
          state_s      = RUN;
        end else begin
          state_s = RUN;
        end
      end
      UPD_WR: begin
        csb_s   = 1'b0;
        web_s   = 1'b0;
        addr_s  = head_s.idx;
        din_s   = ctr_next(sram_dout, head_s.taken);
        pop_s   = 1'b1;
        state_s = RUN;
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // State, sweep pointer, starvation counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= INIT;
      ptr_r             <= {IDX_W{1'b0}};
      starve_cnt_r      <= {SW{1'b0}};
      pred_resp_valid_r <= 1'b0;
      init_done_r       <= 1'b0;
    end else begin
      state_r           <= state_s;
      pred_resp_valid_r <= pred_ready_s;
      if (state_r == INIT) ptr_r <= ptr_r + IDX_W'(1);
      if (upd_rd_s) begin
        starve_cnt_r <= {SW{1'b0}};
      end else if (pred_ready_s && !fifo_empty_s && (starve_cnt_r != SW'(STARVE_MAX))) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
      if ((state_r == INIT) && (state_s == RUN)) init_done_r <= 1'b1;
    end
  end

  // Chip select is held inactive for the whole reset assertion.
  assign sram_csb        = csb_s | ~rst_n;
  assign sram_web        = web_s;
  assign sram_addr       = addr_s;
  assign sram_din        = din_s;
  assign pred_ready      = pred_ready_s;
  assign pred_resp_valid = pred_resp_valid_r;
  assign pred_ctr        = sram_dout;
  assign pred_taken      = sram_dout[1];
  assign init_done       = init_done_r;

`ifdef PHT_PERF_EN
  logic [31:0] perf_pred_r, perf_upd_r, perf_starve_r;

  // Event counters; free-running, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pred_r   <= 32'd0;
      perf_upd_r    <= 32'd0;
      perf_starve_r <= 32'd0;
    end else begin
      if (pred_ready_s)            perf_pred_r   <= perf_pred_r + 32'd1;
      if (pop_s)                   perf_upd_r    <= perf_upd_r + 32'd1;
      if (upd_rd_s && pred_valid)  perf_starve_r <= perf_starve_r + 32'd1;
    end
  end

  assign perf_pred   = perf_pred_r;
  assign perf_upd    = perf_upd_r;
  assign perf_starve = perf_starve_r;
`endif

endmodule

// File: tb/tb_bimodal_pht_ctrl.sv
// Scoreboard bench for bimodal_pht_ctrl with a behavioural single-port SRAM model.
module tb_bimodal_pht_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_ready, pred_resp_valid, pred_taken;
  logic [8:0] pred_idx, upd_idx, sram_addr;
  logic [1:0] pred_ctr, sram_din, sram_dout;
  logic       upd_valid, upd_ready, upd_taken, init_done, sram_csb, sram_web;
`ifdef PHT_PERF_EN
  logic [31:0] perf_pred, perf_upd, perf_starve;
`endif

  always #5 clk = ~clk;

  bimodal_pht_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_idx(pred_idx),
    .pred_resp_valid(pred_resp_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef PHT_PERF_EN
    , .perf_pred(perf_pred), .perf_upd(perf_upd), .perf_starve(perf_starve)
`endif
  );

  // SRAM model: contents start at a value the init sweep must overwrite.
  logic [1:0] mem [512] = '{default: 2'b10};
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout <= mem[sram_addr];
    end
  end

  typedef struct { logic [1:0] ctr; int cyc; } sb_ent_t;
  sb_ent_t    sb_q[$];
  logic [1:0] ref_ctr [512];
  int n_checks = 0, n_errors = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  logic       s_csb, s_web, s_init_done, s_pred_ready, s_upd_ready;
  logic [8:0] s_addr;
  logic [1:0] s_din;

  function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, return just after the rising edge.
  task automatic tick();
    sb_ent_t e;
    @(negedge clk);
    cyc++;
    s_csb = sram_csb; s_web = sram_web; s_addr = sram_addr; s_din = sram_din;
    s_init_done = init_done; s_pred_ready = pred_ready; s_upd_ready = upd_ready;
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) ref_ctr[i] = 2'b01;
      sb_q.delete();
    end else begin
      if (pred_resp_valid) begin
        check_val("resp_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("resp_latency", cyc, e.cyc + 1);
          check_val("pred_ctr", pred_ctr, e.ctr);
          check_val("pred_taken", pred_taken, e.ctr[1]);
        end
      end
      if (pred_valid && pred_ready) sb_q.push_back('{ctr: ref_ctr[pred_idx], cyc: cyc});
      if (upd_valid && upd_ready) ref_ctr[upd_idx] = ref_next(ref_ctr[upd_idx], upd_taken);
      if (!sram_csb && !sram_web) wr_cnt++;
      if (!sram_csb && sram_web)  rd_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_pred(input logic [8:0] idx);
    int n = 0;
    pred_valid = 1'b1; pred_idx = idx;
    do begin tick(); n++; end while (!s_pred_ready && n < 50);
    pred_valid = 1'b0;
    check_val("pred_wait", n < 50, 1);
  endtask

  task automatic push_upd(input logic [8:0] idx, input logic t);
    int n = 0;
    upd_valid = 1'b1; upd_idx = idx; upd_taken = t;
    do begin tick(); n++; end while (!s_upd_ready && n < 50);
    upd_valid = 1'b0;
    check_val("upd_wait", n < 50, 1);
  endtask

  task automatic run_sweep();
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (s_csb !== 1'b0 || s_web !== 1'b0 || s_addr !== 9'(i) || s_din !== 2'b01 || s_init_done !== 1'b0) bad++;
    end
    check_val("sweep_writes", bad, 0);
    tick();
    check_val("init_done_set", s_init_done, 1);
  endtask

  task automatic check_mem_all_init();
    int bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 2'b01) bad++;
    check_val("mem_after_sweep", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int acc, stall, n, w0, r0;
    rst_n = 1'b0; pred_valid = 1'b0; pred_idx = 9'd0;
    upd_valid = 1'b0; upd_idx = 9'd0; upd_taken = 1'b0;

    // 1. reset values, init sweep, predict of the last entry
    idle(3);
    check_val("rst_csb", s_csb, 1);
    check_val("rst_init_done", s_init_done, 0);
    check_val("rst_resp_valid", pred_resp_valid, 0);
    check_val("rst_upd_ready", s_upd_ready, 1);
    rst_n = 1'b1;
    run_sweep();
    check_mem_all_init();
    do_pred(9'h1FF);
    idle(2);

    // 2. three taken updates saturate at 3
    w0 = wr_cnt; r0 = rd_cnt;
    for (int k = 0; k < 3; k++) push_upd(9'd5, 1'b1);
    idle(8);
    check_val("t2_writes", wr_cnt - w0, 3);
    check_val("t2_reads", rd_cnt - r0, 3);
    check_val("t2_mem5", mem[5], 2'b11);
    do_pred(9'd5);
    idle(2);

    // 3. two not-taken updates floor at 0
    push_upd(9'd7, 1'b0);
    push_upd(9'd7, 1'b0);
    idle(6);
    check_val("t3_mem7", mem[7], 2'b00);
    do_pred(9'd7);
    idle(2);

    // 4. starvation limit, twice to show the counter restarts
    for (int r = 0; r < 2; r++) begin
      pred_valid = 1'b1; pred_idx = 9'd30;
      idle(2);
      push_upd(9'd20, 1'b1);
      acc = 0; stall = 0; n = 0;
      do begin tick(); n++; if (s_pred_ready) acc++; end while (s_pred_ready && n < 40);
      stall = 1;
      do begin tick(); n++; if (!s_pred_ready) stall++; end while (!s_pred_ready && n < 40);
      pred_valid = 1'b0;
      check_val("t4_accepts", acc, 8);
      check_val("t4_stall", stall, 2);
      idle(3);
    end
    check_val("t4_mem20", mem[20], ref_ctr[20]);

    // 5. full queue forces the update; push accepted in the pop cycle
    pred_valid = 1'b1; pred_idx = 9'd40;
    tick();
    push_upd(9'd50, 1'b1);
    push_upd(9'd51, 1'b0);
    push_upd(9'd52, 1'b1);
    push_upd(9'd53, 1'b1);
    upd_valid = 1'b1; upd_idx = 9'd54; upd_taken = 1'b0;
    tick();
    check_val("t5_full_ready", s_upd_ready, 0);
    check_val("t5_forced_rd", s_pred_ready, 0);
    tick();
    check_val("t5_pop_ready", s_upd_ready, 1);
    check_val("t5_wr_pred_ready", s_pred_ready, 0);
    upd_valid = 1'b0; pred_valid = 1'b0;
    idle(12);
    for (int i = 50; i < 55; i++) check_val("t5_mem", mem[i], ref_ctr[i]);

    // 6. reset in UPD_WR drops the write and flushes the queue
    push_upd(9'd60, 1'b1);
    tick();
    check_val("t6_rd_issue", {s_csb, s_web, s_addr}, {1'b0, 1'b1, 9'd60});
    check_val("t6_wr_phase", {sram_csb, sram_web, sram_addr}, {1'b0, 1'b0, 9'd60});
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_csb", sram_csb, 1);
    check_val("t6_rst_init_done", init_done, 0);
    idle(3);
    rst_n = 1'b1;
    run_sweep();
    w0 = wr_cnt;
    idle(10);
    check_val("t6_no_stale_write", wr_cnt - w0, 0);
    check_mem_all_init();
    do_pred(9'd60);
    idle(3);
    check_val("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
